// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control and the ALU control unit.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EX   = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// State -> control word decode; reset forces the whole word to zero.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       rst,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = 2'b01;
          ctrl.alu_op    = ALUOP_ADD;
          // IR and PC only advance once the fetch read actually returns
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = 2'b11;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_ADDR, S_ADDI_EX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b10;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write  = 1'b1;
          ctrl.iord       = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_EXECUTE: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = 2'b01;
          ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = 2'b10;
          ctrl.instr_done = 1'b1;
        end
        S_ADDI_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_main_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic, opcode legality.
module mips_multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int ENABLE_ADDI = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  logic [3:0] state_q, state_d;
  logic       legal;
  ctrl_t      ctrl;

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      OP_ADDI: legal = (ENABLE_ADDI != 0);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!legal)                 state_d = S_FETCH;
        else if (opcode == OP_RTYPE) state_d = S_EXECUTE;
        else if (opcode == OP_BEQ)   state_d = S_BRANCH;
        else if (opcode == OP_J)     state_d = S_JUMP;
        else if (opcode == OP_ADDI)  state_d = S_ADDI_EX;
        else                         state_d = S_MEM_ADDR;
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .rst       (rst),
    .ctrl      (ctrl)
  );

  // Illegal opcodes retire straight out of DECODE
  assign illegal_op  = !rst && (state_q == S_DECODE) && !legal;
  assign instr_done  = ctrl.instr_done | illegal_op;
  assign state       = state_q;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;

endmodule

// File: tb/tb_mips_multicycle_main_control.sv
// Directed bench: two instances (addi enabled / disabled) checked against a spec-table scoreboard.
module tb_mips_multicycle_main_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    logic done, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst, mem_ready;
  logic [5:0] opcode;

  logic pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, done1, ill1;
  logic [1:0] asb1, aop1, pcs1;
  logic [3:0] st1;
  logic pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0, done0, ill0;
  logic [1:0] asb0, aop0, pcs0;
  logic [3:0] st0;

  exp_t exp1_q[$], exp0_q[$];
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_main_control #(.ENABLE_ADDI(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1),
    .IRWrite(irw1), .MemtoReg(m2r1), .RegDst(rdst1), .RegWrite(rw1), .ALUSrcA(asa1),
    .ALUSrcB(asb1), .ALUOp(aop1), .PCSource(pcs1), .state(st1), .instr_done(done1),
    .illegal_op(ill1));

  mips_multicycle_main_control #(.ENABLE_ADDI(0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw0), .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mrd0), .MemWrite(mwr0),
    .IRWrite(irw0), .MemtoReg(m2r0), .RegDst(rdst0), .RegWrite(rw0), .ALUSrcA(asa0),
    .ALUSrcB(asb0), .ALUOp(aop0), .PCSource(pcs0), .state(st0), .instr_done(done0),
    .illegal_op(ill0));

  exp_t act1, act0;
  assign act1 = {st1, pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1,
                 asb1, aop1, pcs1, done1, ill1};
  assign act0 = {st0, pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0,
                 asb0, aop0, pcs0, done0, ill0};

  // Expected outputs from the state table, given the state the bench expects to be in
  function automatic exp_t model(input logic r, input logic [3:0] st, input logic mr,
                                 input logic [5:0] op, input logic addi_en);
    exp_t e;
    logic ok;
    e = '0;
    ok = (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == JMP) ||
         (addi_en && op == ADDI);
    if (r) return e;
    e.st = st;
    case (st)
      4'd0:  begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
      4'd1:  begin e.asb = 2'b11; e.ill = !ok; e.done = !ok; end
      4'd2:  begin e.asa = 1; e.asb = 2'b10; end
      4'd3:  begin e.mrd = 1; e.iord = 1; end
      4'd4:  begin e.rw = 1; e.m2r = 1; e.done = 1; end
      4'd5:  begin e.mwr = 1; e.iord = 1; e.done = mr; end
      4'd6:  begin e.asa = 1; e.aop = 2'b10; end
      4'd7:  begin e.rw = 1; e.rdst = 1; e.done = 1; end
      4'd8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.done = 1; end
      4'd9:  begin e.pcw = 1; e.pcs = 2'b10; e.done = 1; end
      4'd10: begin e.asa = 1; e.asb = 2'b10; end
      4'd11: begin e.rw = 1; e.done = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] s1, input logic [3:0] s0, input string tag);
    exp_t e;
    rst = r; opcode = op; mem_ready = mr;
    exp1_q.push_back(model(r, s1, mr, op, 1'b1));
    exp0_q.push_back(model(r, s0, mr, op, 1'b0));
    @(negedge clk);
    e = exp1_q.pop_front();
    n_assert++;
    assert (act1 === e) else begin
      n_fail++;
      $error("FAIL %s addi1: got %h want %h", tag, act1, e);
    end
    e = exp0_q.pop_front();
    n_assert++;
    assert (act0 === e) else begin
      n_fail++;
      $error("FAIL %s addi0: got %h want %h", tag, act0, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic r, input logic [5:0] op, input logic mr,
                       input logic [3:0] s, input string tag);
    step(r, op, mr, s, s, tag);
  endtask

  initial begin
    rst = 1'b1; opcode = '0; mem_ready = 1'b0;
    step1(1, RT, 0, 0, "reset");
    step1(1, RT, 1, 0, "reset");
    // stall in FETCH, then reset lands mid-stall
    step1(0, JMP, 0, 0, "fetch_stall");
    step1(0, BAD, 0, 0, "fetch_stall");
    repeat (3) step1(1, LW, 0, 0, "rst_midstall");
    // lw
    step1(0, LW, 1, 0, "lw_fetch");
    step1(0, LW, 1, 1, "lw_decode");
    step1(0, LW, 1, 2, "lw_addr");
    step1(0, LW, 1, 3, "lw_read");
    step1(0, LW, 1, 4, "lw_wb");
    // R-type
    step1(0, RT, 1, 0, "r_fetch");
    step1(0, RT, 1, 1, "r_decode");
    step1(0, RT, 1, 6, "r_exec");
    step1(0, RT, 1, 7, "r_wb");
    // beq, j
    step1(0, BEQ, 1, 0, "beq_fetch");
    step1(0, BEQ, 1, 1, "beq_decode");
    step1(0, BEQ, 1, 8, "beq_br");
    step1(0, JMP, 1, 0, "j_fetch");
    step1(0, JMP, 1, 1, "j_decode");
    step1(0, JMP, 1, 9, "j_jump");
    // sw with three stall cycles in MEM_WRITE
    step1(0, SW, 1, 0, "sw_fetch");
    step1(0, SW, 1, 1, "sw_decode");
    step1(0, SW, 1, 2, "sw_addr");
    step1(0, SW, 0, 5, "sw_stall");
    step1(0, SW, 0, 5, "sw_stall");
    step1(0, SW, 0, 5, "sw_stall");
    step1(0, SW, 1, 5, "sw_done");
    // opcode churn during FETCH stall must not matter
    step1(0, JMP, 0, 0, "churn_stall");
    step1(0, BEQ, 0, 0, "churn_stall");
    step1(0, RT, 1, 0, "churn_fetch");
    step1(0, RT, 1, 1, "churn_decode");
    step1(0, RT, 1, 6, "churn_exec");
    step1(0, RT, 1, 7, "churn_wb");
    // lw with a MEM_READ stall
    step1(0, LW, 1, 0, "lwst_fetch");
    step1(0, LW, 1, 1, "lwst_decode");
    step1(0, LW, 1, 2, "lwst_addr");
    step1(0, LW, 0, 3, "lwst_stall");
    step1(0, LW, 1, 3, "lwst_read");
    step1(0, LW, 1, 4, "lwst_wb");
    // illegal opcode
    step1(0, BAD, 1, 0, "bad_fetch");
    step1(0, BAD, 1, 1, "bad_decode");
    // addi: legal on one instance, illegal on the other
    step(0, ADDI, 1, 0, 0, "addi_fetch");
    step(0, ADDI, 1, 1, 1, "addi_decode");
    step(0, ADDI, 1, 10, 0, "addi_ex");
    step(0, ADDI, 1, 11, 1, "addi_wb");
    step1(1, RT, 1, 0, "resync_rst");
    // reset during MEM_WB aborts write-back
    step1(0, LW, 1, 0, "abort_fetch");
    step1(0, LW, 1, 1, "abort_decode");
    step1(0, LW, 1, 2, "abort_addr");
    step1(0, LW, 1, 3, "abort_read");
    step1(1, LW, 1, 0, "abort_rst");
    step1(0, LW, 1, 0, "post_rst_fetch");
    step1(0, LW, 1, 1, "post_rst_decode");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_main_control.md
# mips_multicycle_main_control

Main control FSM for the multicycle variant of the 32-bit MIPS core; it sits directly upstream of the ALU control unit. It decodes the 6-bit opcode from the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back states. Every cycle it drives the datapath enables, the mux selects and the 2-bit ALUOp consumed by the ALU control unit. A `mem_ready` handshake stretches the memory states for slow memory.

## Interface
Parameters:
- ENABLE_ADDI, 1, when 1 opcode 001000 (addi) is decoded; when 0 it is treated as illegal

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  6  instr[31:26] from the instruction register; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write qualified by ALU zero (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back source select: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination register select: 0 = rt, 1 = rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs
- ALUSrcB  out  2  ALU B input: 00 = rt, 01 = 4, 10 = signext, 11 = signext<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded; 11 is never driven
- PCSource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
- state  out  4  current state encoding (debug)
- instr_done  out  1  asserted in the final cycle of each instruction
- illegal_op  out  1  asserted in DECODE when the opcode is unsupported

## Operation
- Outputs are decoded from the state register (Moore). The exceptions are PCWrite/IRWrite in FETCH and the `instr_done` term in the memory states, which are additionally qualified by `mem_ready`.
- Any signal not listed for a state is 0.
- FETCH (0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite assert only when mem_ready=1.
  - Hold FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 100011 or 101011 → MEM_ADDR
  - 000000 → EXECUTE
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EX (only when ENABLE_ADDI=1)
  - anything else → FETCH, with illegal_op=1 and instr_done=1
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ (3): MemRead, IorD=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB (4): RegWrite, MemtoReg=1, RegDst=0, instr_done. Next: FETCH.
- MEM_WRITE (5): MemWrite, IorD=1. Hold until mem_ready=1, then FETCH; instr_done asserts in the mem_ready cycle.
- EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: R_WB.
- R_WB (7): RegWrite, RegDst=1, MemtoReg=0, instr_done. Next: FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01, instr_done. Next: FETCH.
- JUMP (9): PCWrite, PCSource=10, instr_done. Next: FETCH.
- ADDI_EX (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDI_WB.
- ADDI_WB (11): RegWrite, RegDst=0, MemtoReg=0, instr_done. Next: FETCH.
- Encodings 12–15 are unreachable; if entered, go to FETCH with all outputs 0.

## Timing
- Reset: the state register is forced to FETCH asynchronously. While rst=1, every output is 0, including MemRead, IRWrite and PCWrite, which are gated by rst.
  - The first FETCH cycle is the first rising edge after rst deasserts.
- Reset mid-instruction aborts immediately; no partial write-back, and nothing is carried over.
- Cycles per instruction with mem_ready held at 1:
  - lw 5, sw 4, R-type 4, beq 3, j 3, addi 4
  - illegal opcode 2 (FETCH, DECODE)
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. All outputs hold stable during the stall.
- opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.
- instr_done is high for exactly one cycle per instruction.
- A new FETCH always immediately follows the instr_done cycle.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - the 4-bit state encodings
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), shared with the ALU control unit
- Sub-module `mips_ctrl_decode` is purely combinational: state + mem_ready + rst → control word.
- The top level holds the state register and the next-state logic.

## Test plan
- Reset: rst=1 for 3 cycles, asserted mid-stall → all outputs 0 and state=0. After release, cycle 1 shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4; RegWrite=1 with MemtoReg=1 only in cycle 5; instr_done once.
- R-type (000000) → ALUOp=10 in EXECUTE; RegDst=1 and RegWrite=1 in R_WB; 4 cycles. beq (000100) → ALUOp=01 and PCWriteCond=1 in cycle 3.
- sw with mem_ready=0 for 3 cycles in MEM_WRITE → MemWrite held for 4 cycles, IorD=1, 7 total cycles, instr_done only in the final cycle.
- Opcode 111111 → illegal_op=1 and instr_done=1 in DECODE, then FETCH. With ENABLE_ADDI=0, 001000 behaves the same; with ENABLE_ADDI=1 it completes in 4 cycles with ALUSrcB=10.
- rst asserted during MEM_WB → RegWrite drops in the same cycle and state returns to FETCH. opcode toggled during FETCH stall cycles → no effect on the next-state decision.
